// File: rtl/joystick_spi_responder.sv
// SPI mode-0 slave emulating the 2-axis joystick: 5-byte frames, x/y/button readback, LED command decode.
// Optional JSTK_MISO_TRISTATE_EN: release miso (1'bz) whenever no frame is in progress.
module joystick_spi_responder #(
    parameter int         FRAME_BYTES = 5,
    parameter int         SYNC_STAGES = 2,
    parameter logic [5:0] CMD_PREFIX  = 6'b100000
) (
    input  logic       clk50M,
    input  logic       rst_n,
    input  logic [9:0] x_in,
    input  logic [9:0] y_in,
    input  logic [2:0] btn_in,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    output logic [1:0] led,
    output logic       cmd_valid,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int FRAME_BITS = FRAME_BYTES * 8;
    localparam int CTR_W      = $clog2(FRAME_BITS + 1);
    localparam logic [CTR_W-1:0] CTR_FULL = CTR_W'(FRAME_BITS);
    localparam logic [CTR_W-1:0] CMD_BITS = CTR_W'(8);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;
    logic [FRAME_BITS-1:0]  r_tx;
    logic [7:0]             r_cmd;
    logic [CTR_W-1:0]       r_bit_ctr;
    logic                   r_miso;
    logic [1:0]             r_led;
    logic                   r_cmd_valid;
    logic                   r_frame_done;
    logic                   r_frame_err;
    logic [FRAME_BITS-1:0]  w_snap;
    logic                   w_sck_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_sck_rise;
    logic                   w_sck_fall;
    logic                   w_cs_rise;
    logic                   w_cs_fall;

    // cs synchronizer resets to 0 so a cs already low at reset release never looks like a new frame.
    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_cs_d      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_d     <= w_sck_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_cs_rise  = w_cs_s & ~r_cs_d;
    assign w_cs_fall  = ~w_cs_s & r_cs_d;

    always_comb begin
        w_snap = '0;
        w_snap[FRAME_BITS-1 -: 40] = {x_in[7:0], 6'b0, x_in[9:8],
                                      y_in[7:0], 6'b0, y_in[9:8],
                                      5'b0, btn_in};
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_next_state = SHIFT;
            SHIFT:   if (w_cs_rise) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_tx         <= '0;
            r_cmd        <= '0;
            r_bit_ctr    <= '0;
            r_miso       <= 1'b0;
            r_led        <= 2'b00;
            r_cmd_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_cmd_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            if (r_state == IDLE) begin
                // sck edges coinciding with the cs fall are deliberately dropped here.
                if (w_cs_fall) begin
                    r_tx      <= w_snap;
                    r_miso    <= w_snap[FRAME_BITS-1];
                    r_bit_ctr <= '0;
                end
            end else if (w_cs_rise) begin
                r_miso <= 1'b0;
                if (r_bit_ctr >= CTR_FULL) begin
                    r_frame_done <= 1'b1;
                    if (r_cmd[7:2] == CMD_PREFIX) begin
                        r_led       <= r_cmd[1:0];
                        r_cmd_valid <= 1'b1;
                    end
                end else begin
                    r_frame_err <= 1'b1;
                end
            end else begin
                if (w_sck_rise) begin
                    if (r_bit_ctr < CMD_BITS) r_cmd <= {r_cmd[6:0], w_mosi_s};
                    if (r_bit_ctr != CTR_FULL) r_bit_ctr <= r_bit_ctr + 1'b1;
                end
                // Zero-fill drains the frame so bits past the end read as 0.
                if (w_sck_fall) begin
                    r_tx   <= r_tx << 1;
                    r_miso <= r_tx[FRAME_BITS-2];
                end
            end
        end
    end

`ifdef JSTK_MISO_TRISTATE_EN
    assign miso = (r_state == SHIFT) ? r_miso : 1'bz;
`else
    assign miso = r_miso;
`endif
    assign led        = r_led;
    assign cmd_valid  = r_cmd_valid;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign busy       = (r_state == SHIFT);

endmodule

// File: tb/tb_joystick_spi_responder.sv
// Bench for joystick_spi_responder: SPI master driver, pulse monitor and a byte-level frame model.
module tb_joystick_spi_responder;

    logic       clk50M = 1'b0;
    logic       rst_n;
    logic [9:0] x_in, y_in;
    logic [2:0] btn_in;
    logic       sck, cs, mosi;
    wire        miso;
    logic [1:0] led;
    logic       cmd_valid, frame_done, frame_err, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_done = 0, cnt_valid = 0, cnt_err = 0;
    int m_done = 0, m_valid = 0, m_err = 0;
    logic [1:0] m_led = 2'b00;

    always #10 clk50M = ~clk50M;

    joystick_spi_responder dut (
        .clk50M(clk50M), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .btn_in(btn_in),
        .sck(sck), .cs(cs), .mosi(mosi), .miso(miso), .led(led),
        .cmd_valid(cmd_valid), .frame_done(frame_done), .frame_err(frame_err), .busy(busy)
    );

    always @(negedge clk50M) begin
        if (frame_done) cnt_done++;
        if (cmd_valid)  cnt_valid++;
        if (frame_err)  cnt_err++;
    end

    // Expected miso stream: five bytes laid out per the joystick protocol, left-aligned, zeros after.
    function automatic logic [63:0] model_stream(input int x, input int y, input int b);
        int bytes[5];
        logic [63:0] s;
        bytes[0] = x % 256;
        bytes[1] = x / 256;
        bytes[2] = y % 256;
        bytes[3] = y / 256;
        bytes[4] = b;
        s = '0;
        for (int k = 0; k < 5; k++) s[63 - 8*k -: 8] = bytes[k][7:0];
        return s;
    endfunction

    function automatic logic [63:0] first_bits(input int n);
        logic [63:0] ones;
        ones = '1;
        return ~(ones >> n);
    endfunction

    task automatic model_frame(input int nbits, input logic [7:0] c);
        if (nbits >= 40) begin
            m_done++;
            if (c[7:2] == 6'b100000) begin
                m_led = c[1:0];
                m_valid++;
            end
        end else begin
            m_err++;
        end
    endtask

    task automatic run_frame(input int nbits, input logic [63:0] mo, input int chg_at,
                             input logic [9:0] chg_x, output logic [63:0] mi, output logic busy_mid);
        mi = '0;
        busy_mid = 1'b0;
        @(negedge clk50M);
        cs = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) x_in = chg_x;
            mosi = mo[63-i];
            repeat (5) @(negedge clk50M);
            mi[63-i] = miso;
            if (i == 1) busy_mid = busy;
            sck = 1'b1;
            repeat (5) @(negedge clk50M);
            sck = 1'b0;
        end
        repeat (5) @(negedge clk50M);
        cs = 1'b1;
        repeat (8) @(negedge clk50M);
        model_frame(nbits, mo[63:56]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        x_in = '0; y_in = '0; btn_in = '0;
        repeat (3) @(negedge clk50M);
        n_tests++;
        if ({miso, led, busy, cmd_valid, frame_done, frame_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b required 0000000",
                     {miso, led, busy, cmd_valid, frame_done, frame_err});
        end
        rst_n = 1'b1;
        repeat (6) @(negedge clk50M);
        n_tests++;
        if (cnt_done + cnt_valid + cnt_err !== 0) begin
            n_fail++;
            $display("FAIL reset_no_pulses got %0d required 0", cnt_done + cnt_valid + cnt_err);
        end
    endtask

    task automatic test_basic_frame();
        logic [63:0] mi, ex;
        logic bm;
        x_in = 10'h2A5; y_in = 10'h13C; btn_in = 3'b101;
        ex = model_stream(10'h2A5, 10'h13C, 5);
        run_frame(40, {8'h83, 56'h0}, -1, 10'h0, mi, bm);
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if (mi[63 - 8*k -: 8] !== ex[63 - 8*k -: 8]) begin
                n_fail++;
                $display("FAIL t1_miso_byte%0d got %h required %h", k, mi[63 - 8*k -: 8], ex[63 - 8*k -: 8]);
            end
        end
        n_tests++;
        if (bm !== 1'b1) begin n_fail++; $display("FAIL t1_busy_mid got %b required 1", bm); end
        n_tests++;
        if (led !== 2'b11) begin n_fail++; $display("FAIL t1_led got %b required 11", led); end
        n_tests++;
        if (cnt_valid !== m_valid || cnt_done !== m_done) begin
            n_fail++;
            $display("FAIL t1_pulses got valid=%0d done=%0d required valid=%0d done=%0d",
                     cnt_valid, cnt_done, m_valid, m_done);
        end
        n_tests++;
        if (busy !== 1'b0 || miso !== 1'b0) begin
            n_fail++; $display("FAIL t1_idle got busy=%b miso=%b required 0 0", busy, miso);
        end
    endtask

    task automatic test_bad_cmd();
        logic [63:0] mi;
        logic bm;
        run_frame(40, {8'h42, 56'h0}, -1, 10'h0, mi, bm);
        n_tests++;
        if (led !== m_led) begin n_fail++; $display("FAIL t2_led got %b required %b", led, m_led); end
        n_tests++;
        if (cnt_done !== m_done || cnt_valid !== m_valid) begin
            n_fail++;
            $display("FAIL t2_pulses got done=%0d valid=%0d required done=%0d valid=%0d",
                     cnt_done, cnt_valid, m_done, m_valid);
        end
    endtask

    task automatic test_short_frame();
        logic [63:0] mi;
        logic bm;
        run_frame(20, {8'h80, 56'h0}, -1, 10'h0, mi, bm);
        n_tests++;
        if (cnt_err !== m_err || cnt_done !== m_done) begin
            n_fail++;
            $display("FAIL t3_err got err=%0d done=%0d required err=%0d done=%0d", cnt_err, cnt_done, m_err, m_done);
        end
        n_tests++;
        if (led !== m_led || busy !== 1'b0 || miso !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_state got led=%b busy=%b miso=%b required led=%b busy=0 miso=0", led, busy, miso, m_led);
        end
        run_frame(40, {8'h81, 56'h0}, -1, 10'h0, mi, bm);
        n_tests++;
        if (led !== 2'b01) begin n_fail++; $display("FAIL t3_recover_led got %b required 01", led); end
    endtask

    task automatic test_midframe_input_change();
        logic [63:0] mi, ex;
        logic bm;
        x_in = 10'h2A5; y_in = 10'h13C; btn_in = 3'b101;
        ex = model_stream(10'h2A5, 10'h13C, 5);
        run_frame(40, {8'h83, 56'h0}, 8, 10'h3FF, mi, bm);
        n_tests++;
        if ((mi & first_bits(40)) !== ex) begin
            n_fail++; $display("FAIL t4_snapshot got %h required %h", mi, ex);
        end
        ex = model_stream(10'h3FF, 10'h13C, 5);
        run_frame(40, {8'h83, 56'h0}, -1, 10'h0, mi, bm);
        n_tests++;
        if ((mi & first_bits(40)) !== ex) begin
            n_fail++; $display("FAIL t4_next_frame got %h required %h", mi, ex);
        end
    endtask

    task automatic test_reset_midframe();
        logic [63:0] mi, ex;
        logic bm;
        int d0, v0, e0;
        @(negedge clk50M);
        cs = 1'b0;
        for (int i = 0; i < 17; i++) begin
            mosi = (i < 8) ? ((8'h83 >> (7 - i)) & 1) : 1'b0;
            repeat (5) @(negedge clk50M);
            sck = 1'b1;
            repeat (5) @(negedge clk50M);
            sck = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        m_led = 2'b00;
        n_tests++;
        if ({miso, led, busy, cmd_valid, frame_done, frame_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL t5_async_reset got %b required 0000000",
                     {miso, led, busy, cmd_valid, frame_done, frame_err});
        end
        d0 = cnt_done; v0 = cnt_valid; e0 = cnt_err;
        repeat (3) @(negedge clk50M);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mosi = 1'($urandom);
            repeat (5) @(negedge clk50M);
            sck = 1'b1;
            repeat (5) @(negedge clk50M);
            sck = 1'b0;
        end
        n_tests++;
        if (busy !== 1'b0 || miso !== 1'b0) begin
            n_fail++; $display("FAIL t5_no_resync got busy=%b miso=%b required 0 0", busy, miso);
        end
        cs = 1'b1;
        repeat (10) @(negedge clk50M);
        n_tests++;
        if (cnt_done !== d0 || cnt_valid !== v0 || cnt_err !== e0 || led !== 2'b00) begin
            n_fail++;
            $display("FAIL t5_silent got done=%0d valid=%0d err=%0d led=%b required %0d %0d %0d 00",
                     cnt_done, cnt_valid, cnt_err, led, d0, v0, e0);
        end
        x_in = 10'h155; y_in = 10'h2AA; btn_in = 3'b011;
        ex = model_stream(10'h155, 10'h2AA, 3);
        run_frame(40, {8'h82, 56'h0}, -1, 10'h0, mi, bm);
        n_tests++;
        if ((mi & first_bits(40)) !== ex || led !== 2'b10) begin
            n_fail++; $display("FAIL t5_next_frame got %h led=%b required %h led=10", mi, led, ex);
        end
    endtask

    task automatic test_long_frame();
        logic [63:0] mi, ex;
        logic bm;
        x_in = 10'h3FF; y_in = 10'h3FF; btn_in = 3'b111;
        ex = model_stream(10'h3FF, 10'h3FF, 7);
        run_frame(45, {8'h81, 56'hFF_FFFF_FFFF_FFFF}, -1, 10'h0, mi, bm);
        n_tests++;
        if ((mi & first_bits(45)) !== ex) begin
            n_fail++; $display("FAIL t6_stream got %h required %h", mi, ex);
        end
        n_tests++;
        if (mi[23:19] !== 5'b0) begin
            n_fail++; $display("FAIL t6_extra_bits got %b required 00000", mi[23:19]);
        end
        n_tests++;
        if (led !== 2'b01 || cnt_done !== m_done || cnt_valid !== m_valid) begin
            n_fail++;
            $display("FAIL t6_pulses got led=%b done=%0d valid=%0d required 01 %0d %0d",
                     led, cnt_done, cnt_valid, m_done, m_valid);
        end
    endtask

    task automatic test_random_frames();
        logic [63:0] mi, ex, mo;
        logic bm;
        int nb, x, y, b;
        for (int t = 0; t < 12; t++) begin
            x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); b = $urandom_range(0, 7);
            x_in = 10'(x); y_in = 10'(y); btn_in = 3'(b);
            ex = model_stream(x, y, b);
            case ($urandom_range(0, 3))
                0:       nb = $urandom_range(1, 39);
                1:       nb = $urandom_range(41, 48);
                default: nb = 40;
            endcase
            mo = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) mo[63:58] = 6'b100000;
            run_frame(nb, mo, -1, 10'h0, mi, bm);
            n_tests++;
            if ((mi & first_bits(nb)) !== (ex & first_bits(nb))) begin
                n_fail++; $display("FAIL rand%0d_miso n=%0d got %h required %h", t, nb, mi, ex & first_bits(nb));
            end
            n_tests++;
            if (led !== m_led || cnt_done !== m_done || cnt_valid !== m_valid || cnt_err !== m_err) begin
                n_fail++;
                $display("FAIL rand%0d_ctrl got led=%b d=%0d v=%0d e=%0d required led=%b d=%0d v=%0d e=%0d",
                         t, led, cnt_done, cnt_valid, cnt_err, m_led, m_done, m_valid, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_bad_cmd();
        test_short_frame();
        test_midframe_input_change();
        test_reset_midframe();
        test_long_frame();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
